// File: rtl/gg_prod_accum_if.sv
// Handshake/data bundle between the sum/product stream source, gg_prod_accum and its result consumer.
// ACC_W must match the ACC_W of the gg_prod_accum instance it is bound to.
interface gg_prod_accum_if #(
    parameter int ACC_W = 24
);
    logic             start;
    logic             inValid;
    logic [15:0]      sum;
    logic [15:0]      prod;
    logic             busy;
    logic [ACC_W-1:0] accSum;
    logic [ACC_W-1:0] accProd;
    logic             ovf;
    logic             outValid;
    logic             outReady;

    modport master (
        output start, inValid, sum, prod, outReady,
        input  busy, accSum, accProd, ovf, outValid
    );

    modport slave (
        input  start, inValid, sum, prod, outReady,
        output busy, accSum, accProd, ovf, outValid
    );
endinterface

// File: rtl/gg_prod_accum.sv
// Accumulates N_SAMPLES sum/prod pairs into wide totals and offers them on a valid/ready port.
// Optional macro GG_ACC_SAT_EN: accumulators saturate at all-ones instead of wrapping.
module gg_prod_accum #(
    parameter int N_SAMPLES = 8,
    parameter int ACC_W     = 24
) (
    input  logic           clk,
    input  logic           reset,
    gg_prod_accum_if.slave ifc
);
    localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_count;
    logic [ACC_W-1:0] r_accSum;
    logic [ACC_W-1:0] r_accProd;
    logic             r_ovf;
    logic             r_busy;
    logic             r_outValid;

    logic             w_take;
    logic             w_clear;
    logic [ACC_W:0]   w_sumAdd;
    logic [ACC_W:0]   w_prodAdd;
    logic [ACC_W-1:0] w_sumNext;
    logic [ACC_W-1:0] w_prodNext;

    // One extra bit on each adder exposes the carry out of bit ACC_W-1.
    assign w_sumAdd  = {1'b0, r_accSum}  + {{(ACC_W+1-16){1'b0}}, ifc.sum};
    assign w_prodAdd = {1'b0, r_accProd} + {{(ACC_W+1-16){1'b0}}, ifc.prod};

`ifdef GG_ACC_SAT_EN
    // A clamped accumulator stays at all-ones: any further add carries again.
    assign w_sumNext  = w_sumAdd[ACC_W]  ? {ACC_W{1'b1}} : w_sumAdd[ACC_W-1:0];
    assign w_prodNext = w_prodAdd[ACC_W] ? {ACC_W{1'b1}} : w_prodAdd[ACC_W-1:0];
`else
    assign w_sumNext  = w_sumAdd[ACC_W-1:0];
    assign w_prodNext = w_prodAdd[ACC_W-1:0];
`endif

    always_comb begin
        w_stateNext = r_state;
        w_take      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ifc.start) begin
                    w_clear     = 1'b1;
                    w_stateNext = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (ifc.inValid) begin
                    w_take = 1'b1;
                    if (r_count == LAST_IDX) begin
                        w_stateNext = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (r_outValid && ifc.outReady) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // busy/outValid are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_accSum   <= '0;
            r_accProd  <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_busy     <= (w_stateNext != ST_IDLE);
            r_outValid <= (w_stateNext == ST_HOLD);
            if (w_clear) begin
                r_count   <= '0;
                r_accSum  <= '0;
                r_accProd <= '0;
                r_ovf     <= 1'b0;
            end else if (w_take) begin
                r_count   <= r_count + 1'b1;
                r_accSum  <= w_sumNext;
                r_accProd <= w_prodNext;
                r_ovf     <= r_ovf | w_sumAdd[ACC_W] | w_prodAdd[ACC_W];
            end
        end
    end

    assign ifc.busy     = r_busy;
    assign ifc.accSum   = r_accSum;
    assign ifc.accProd  = r_accProd;
    assign ifc.ovf      = r_ovf;
    assign ifc.outValid = r_outValid;

endmodule

// File: tb/tb_gg_prod_accum.sv
// Self-checking bench for gg_prod_accum: default, 2-sample/16-bit overflow and 1-sample instances.
module tb_gg_prod_accum;
    typedef logic [15:0] vec8_t [8];

    typedef struct {
        logic [15:0] s;
        logic [15:0] p;
        bit          gapped;
        logic [23:0] eS;
        logic [23:0] eP;
        logic        eO;
    } vec_t;

    typedef struct {
        logic [23:0] s;
        logic [23:0] p;
        logic        o;
    } exp_t;

`ifdef GG_ACC_SAT_EN
    localparam logic [15:0] EXP_B_PROD = 16'hFFFF;
`else
    localparam logic [15:0] EXP_B_PROD = 16'hFC02;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sbq[$];
    vec_t tbl[4];

    gg_prod_accum_if #(.ACC_W(24)) ifA ();
    gg_prod_accum_if #(.ACC_W(16)) ifB ();
    gg_prod_accum_if #(.ACC_W(24)) ifC ();

    gg_prod_accum #(.N_SAMPLES(8), .ACC_W(24)) dutA (.clk(clk), .reset(reset), .ifc(ifA));
    gg_prod_accum #(.N_SAMPLES(2), .ACC_W(16)) dutB (.clk(clk), .reset(reset), .ifc(ifB));
    gg_prod_accum #(.N_SAMPLES(1), .ACC_W(24)) dutC (.clk(clk), .reset(reset), .ifc(ifC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [47:0] actual, input logic [47:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Runs one 8-sample job on dutA and queues its expected totals.
    task automatic applyStimulus(input vec8_t s, input vec8_t p, input bit gapped,
                                 input logic [23:0] eS, input logic [23:0] eP, input logic eO);
        sbq.push_back('{s: eS, p: eP, o: eO});
        ifA.start = 1'b1;
        step();
        ifA.start = 1'b0;
        checkVal("busyAfterStart", 48'(ifA.busy), 48'(1));
        for (int i = 0; i < 8; i++) begin
            if (gapped) begin
                ifA.inValid = 1'b0;
                ifA.sum     = 16'hDEAD;
                ifA.prod    = 16'hBEEF;
                step();
            end
            ifA.inValid = 1'b1;
            ifA.sum     = s[i];
            ifA.prod    = p[i];
            step();
            if (i < 7) checkVal("earlyOutValid", 48'(ifA.outValid), 48'(0));
        end
        ifA.inValid = 1'b0;
        checkVal("validAfterLast", 48'(ifA.outValid), 48'(1));
    endtask

    task automatic checkOutput();
        int   waited;
        exp_t e;
        waited = 0;
        while (!ifA.outValid && waited < 50) begin
            step();
            waited++;
        end
        if (!ifA.outValid) begin
            checkVal("outValidTimeout", 48'(ifA.outValid), 48'(1));
            return;
        end
        if (sbq.size() == 0) begin
            checkVal("unexpectedResult", 48'(sbq.size()), 48'(1));
            return;
        end
        e = sbq.pop_front();
        checkVal("accSum", 48'(ifA.accSum), 48'(e.s));
        checkVal("accProd", 48'(ifA.accProd), 48'(e.p));
        checkVal("ovf", 48'(ifA.ovf), 48'(e.o));
        ifA.outReady = 1'b1;
        step();
        ifA.outReady = 1'b0;
        checkVal("validAfterXfer", 48'(ifA.outValid), 48'(0));
        checkVal("busyAfterXfer", 48'(ifA.busy), 48'(0));
        checkVal("sumStableIdle", 48'(ifA.accSum), 48'(e.s));
    endtask

    initial begin
        vec8_t s;
        vec8_t p;
        checks = 0;
        errors = 0;
        tbl[0] = '{s: 16'd20,    p: 16'd100,   gapped: 1'b0, eS: 24'd160,     eP: 24'd800,     eO: 1'b0};
        tbl[1] = '{s: 16'd1,     p: 16'd1,     gapped: 1'b1, eS: 24'd8,       eP: 24'd8,       eO: 1'b0};
        tbl[2] = '{s: 16'hFFFF,  p: 16'hFFFF,  gapped: 1'b0, eS: 24'h07FFF8,  eP: 24'h07FFF8,  eO: 1'b0};
        tbl[3] = '{s: 16'h1234,  p: 16'h00FF,  gapped: 1'b1, eS: 24'h0091A0,  eP: 24'h0007F8,  eO: 1'b0};

        ifA.start = 0; ifA.inValid = 0; ifA.sum = 0; ifA.prod = 0; ifA.outReady = 0;
        ifB.start = 0; ifB.inValid = 0; ifB.sum = 0; ifB.prod = 0; ifB.outReady = 0;
        ifC.start = 0; ifC.inValid = 0; ifC.sum = 0; ifC.prod = 0; ifC.outReady = 0;
        reset = 1'b0;
        step();
        step();
        checkVal("rstBusy", 48'(ifA.busy), 48'(0));
        checkVal("rstValid", 48'(ifA.outValid), 48'(0));
        checkVal("rstAccSum", 48'(ifA.accSum), 48'(0));
        checkVal("rstAccProd", 48'(ifA.accProd), 48'(0));
        checkVal("rstOvf", 48'(ifA.ovf), 48'(0));
        reset = 1'b1;
        step();

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) begin
                s[i] = tbl[t].s;
                p[i] = tbl[t].p;
            end
            applyStimulus(s, p, tbl[t].gapped, tbl[t].eS, tbl[t].eP, tbl[t].eO);
            checkOutput();
        end

        for (int k = 1; k <= 8; k++) begin
            s[k-1] = 16'(k);
            p[k-1] = 16'(k * k);
        end
        applyStimulus(s, p, 1'b1, 24'd36, 24'd204, 1'b0);
        checkOutput();

        // Backpressure: HOLD must ignore start and in_valid while out_ready is low.
        for (int i = 0; i < 8; i++) begin
            s[i] = 16'd20;
            p[i] = 16'd100;
        end
        applyStimulus(s, p, 1'b0, 24'd160, 24'd800, 1'b0);
        for (int c = 0; c < 5; c++) begin
            ifA.start = 1'b1; ifA.inValid = 1'b1; ifA.sum = 16'd5; ifA.prod = 16'd5;
            step();
            checkVal("bpValid", 48'(ifA.outValid), 48'(1));
            checkVal("bpAccSum", 48'(ifA.accSum), 48'(160));
            checkVal("bpAccProd", 48'(ifA.accProd), 48'(800));
        end
        ifA.start = 1'b0;
        ifA.inValid = 1'b0;
        checkOutput();

        // Reset after three samples discards the partial run.
        ifA.start = 1'b1;
        step();
        ifA.start = 1'b0;
        ifA.inValid = 1'b1; ifA.sum = 16'd9; ifA.prod = 16'd9;
        step(); step(); step();
        ifA.inValid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        checkVal("midRstBusy", 48'(ifA.busy), 48'(0));
        checkVal("midRstValid", 48'(ifA.outValid), 48'(0));
        checkVal("midRstSum", 48'(ifA.accSum), 48'(0));
        checkVal("midRstProd", 48'(ifA.accProd), 48'(0));
        for (int i = 0; i < 8; i++) begin
            s[i] = 16'd0;
            p[i] = 16'd1;
        end
        applyStimulus(s, p, 1'b0, 24'd0, 24'd8, 1'b0);
        checkOutput();
        checkVal("sbEmpty", 48'(sbq.size()), 48'(0));

        // Two-sample, 16-bit overflow run.
        ifB.start = 1'b1;
        step();
        ifB.start = 1'b0;
        ifB.inValid = 1'b1; ifB.sum = 16'd0; ifB.prod = 16'hFE01;
        step();
        checkVal("ovfB1", 48'(ifB.ovf), 48'(0));
        checkVal("prodB1", 48'(ifB.accProd), 48'(16'hFE01));
        step();
        ifB.inValid = 1'b0;
        checkVal("validB", 48'(ifB.outValid), 48'(1));
        checkVal("prodB", 48'(ifB.accProd), 48'(EXP_B_PROD));
        checkVal("ovfB", 48'(ifB.ovf), 48'(1));
        ifB.outReady = 1'b1;
        step();
        ifB.outReady = 1'b0;
        checkVal("validBAfter", 48'(ifB.outValid), 48'(0));
        checkVal("ovfBSticky", 48'(ifB.ovf), 48'(1));
        checkVal("prodBStable", 48'(ifB.accProd), 48'(EXP_B_PROD));

        // Single-sample run with out_ready already high.
        ifC.start = 1'b1;
        step();
        ifC.start = 1'b0;
        ifC.outReady = 1'b1;
        ifC.inValid = 1'b1; ifC.sum = 16'd3; ifC.prod = 16'd7;
        step();
        ifC.inValid = 1'b0;
        checkVal("validC", 48'(ifC.outValid), 48'(1));
        checkVal("prodC", 48'(ifC.accProd), 48'(7));
        checkVal("sumC", 48'(ifC.accSum), 48'(3));
        step();
        checkVal("validCOneCycle", 48'(ifC.outValid), 48'(0));
        checkVal("busyCIdle", 48'(ifC.busy), 48'(0));
        ifC.outReady = 1'b0;
        ifC.start = 1'b1;
        step();
        ifC.start = 1'b0;
        checkVal("busyCRestart", 48'(ifC.busy), 48'(1));
        checkVal("prodCCleared", 48'(ifC.accProd), 48'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gg_prod_accum.md
# gg_prod_accum

Downstream accumulation stage for the registered sum/product unit. It consumes one registered `sum`/`prod` pair per qualified cycle and accumulates N_SAMPLES pairs into wide running totals. It then presents the totals on a valid/ready output port until they are accepted. It turns the per-sample arithmetic stream into block-level dot-product and sum results for the next consumer.

## Interface

- N_SAMPLES, 8, samples per accumulation run; legal range 1..65535.
- ACC_W, 24, accumulator width in bits; legal range 16..48.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  reset; synchronous, active-low.
- start  in  1  single-cycle pulse; begins a run, honoured only in IDLE.
- in_valid  in  1  `sum`/`prod` inputs hold a sample this cycle.
- sum  in  16  registered sum from the upstream stage.
- prod  in  16  registered product from the upstream stage.
- busy  out  1  high in ACCUM and HOLD.
- acc_sum  out  ACC_W  accumulated `sum` total.
- acc_prod  out  ACC_W  accumulated `prod` total.
- ovf  out  1  high if either accumulator overflowed during the current or last run.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer accepts the result.

## Operation

- State machine: IDLE, ACCUM, HOLD.
  - IDLE: `start`=1 → clear `acc_sum`, `acc_prod`, `ovf` and the sample counter; go to ACCUM.
  - ACCUM: each cycle with `in_valid`=1 adds zero-extended `sum` to `acc_sum`, adds zero-extended `prod` to `acc_prod`, and increments the counter.
  - ACCUM: a valid sample with counter = N_SAMPLES-1 goes to HOLD.
  - HOLD: `out_valid`=1; `out_valid` & `out_ready` → IDLE.
- `in_valid` is ignored in IDLE and HOLD.
- `start` is ignored in ACCUM and HOLD; it is not queued.
- Counter width is max(1, $clog2(N_SAMPLES)). Counter resets to 0 on `start`.
- Overflow is detected per accumulator as a carry out of bit ACC_W-1. It sets sticky `ovf`; handling of the overflowed value is set by the Configuration section.
- Results remain stable on `acc_*`/`ovf` after acceptance, through IDLE, until the next `start`.
- In-band gaps (`in_valid`=0 in ACCUM) stall the run indefinitely; there is no timeout.
- Reset: in any state, `reset`=0 at a clock edge → IDLE.
  - On that edge, `acc_sum`=0, `acc_prod`=0, `ovf`=0, counter=0, `out_valid`=0 and `busy`=0.
  - Reset mid-run discards partial totals.

## Timing

- `start` at edge k → `busy`=1 from k+1; the first sample is accepted at edge k+1 at the earliest.
- The last valid sample, sampled at edge m, produces updated totals and `out_valid`=1 visible after edge m, with no extra latency.
- Handshake: a transfer occurs at an edge where `out_valid`=1 and `out_ready`=1.
  - `out_valid` falls the following cycle.
  - `out_ready` may be high before `out_valid`; the transfer completes on the first cycle `out_valid` is high.
- Back-to-back runs: `start` is accepted in the cycle after the transfer, at the earliest.
  - Minimum run period is N_SAMPLES+2 cycles.
- `out_valid` does not depend combinationally on `out_ready`. All outputs are registered.
- With N_SAMPLES=1, one valid sample goes directly ACCUM → HOLD.

## Configuration

- `GG_ACC_SAT_EN` defined: on overflow, an accumulator clamps to 2^ACC_W-1 and holds there for the rest of the run; `ovf` sets.
- `GG_ACC_SAT_EN` undefined: accumulators wrap modulo 2^ACC_W; `ovf` still sets on the first carry out.
- Default build leaves `GG_ACC_SAT_EN` undefined.

## Test plan

- Nominal run: defaults; `start`, then 8 samples `sum`=20, `prod`=100 → `acc_sum`=160, `acc_prod`=800, `ovf`=0; `out_valid` high the cycle after the 8th sample.
- Gapped input: 8 samples with `in_valid` toggling 1/0; `sum`=k, `prod`=k·k for k=1..8 → `acc_sum`=36, `acc_prod`=204; invalid cycles add nothing.
- Backpressure: hold `out_ready`=0 for 5 cycles in HOLD while driving `in_valid`=1 and `start`=1 → `out_valid` stays high and totals stay unchanged.
  - Then pulse `out_ready` → IDLE, `busy`=0 next cycle.
- Overflow: N_SAMPLES=2, ACC_W=16, `prod`=0xFE01 twice.
  - Without the macro: `acc_prod`=0xFC02, `ovf`=1.
  - With `GG_ACC_SAT_EN`: `acc_prod`=0xFFFF, `ovf`=1.
- Reset mid-run: defaults; after 3 samples drive `reset`=0 for 1 cycle → all outputs 0, state IDLE.
  - A new run of 8 samples with `prod`=1 then gives `acc_prod`=8.
- N_SAMPLES=1 run with simultaneous `out_ready`=1: one sample with `prod`=7 → `out_valid` for exactly 1 cycle, `acc_prod`=7.
  - A `start` in the next cycle is accepted.
